// File: rtl/mtsp_issue_pkg.sv
// Shared types for the MO issue sequencer: lane descriptors, issue slots and FSM states.
// Also holds the helpers that classify a phase's lanes.
package mtsp_issue_pkg;

   localparam int DESC_W  = 7;
   localparam int WADDR_W = 7;
   localparam int LANES   = 4;

   typedef struct packed {
      logic       nen;
      logic       alt;
      logic       sel;
      logic [3:0] mo;
   } modesc_t;

   // lane[3] is X, lane[0] is W, so the packed layout matches the {X,Y,Z,W} port order
   typedef struct packed {
      modesc_t [LANES-1:0] lane;
      logic [3:0]          mask;
      logic [WADDR_W-1:0]  waddr;
      logic                phase;
   } slot_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      PH0  = 2'd1,
      PH1  = 2'd2
   } issue_state_t;

   function automatic logic phase_empty(input modesc_t [LANES-1:0] lanes);
      return lanes[3].nen & lanes[2].nen & lanes[1].nen & lanes[0].nen;
   endfunction

   function automatic logic [3:0] lane_wen(input modesc_t [LANES-1:0] lanes);
      return {~lanes[3].nen, ~lanes[2].nen, ~lanes[1].nen, ~lanes[0].nen};
   endfunction

endpackage

// File: rtl/mtsp_issue_slot_reg.sv
// Load/hold register for one issue slot with asynchronous active-low clear.
// Used for both the visible output slot and the phase #1 holding buffer.
module mtsp_issue_slot_reg
   import mtsp_issue_pkg::*;
(
   input  logic  clk,
   input  logic  rst_n,
   input  logic  load,
   input  slot_t slot_in,
   output slot_t slot_out
);

   slot_t slot_d;
   slot_t slot_q;

   always_comb begin
      slot_d = load ? slot_in : slot_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         slot_q <= '0;
      end else begin
         slot_q <= slot_d;
      end
   end

   assign slot_out = slot_q;

endmodule

// File: rtl/mtsp_mo_issue_seq.sv
// Serialises dispatched MO bundles into per-phase issue slots for the vector ALU pipe,
// phase #0 first, skipping phases whose lanes are all disabled.
module mtsp_mo_issue_seq
   import mtsp_issue_pkg::*;
#(
   parameter int MODESC_W = DESC_W,
   parameter int GPR_AW   = WADDR_W,
   parameter int CNT_W    = 16
) (
   input  logic                  CLK,
   input  logic                  nRST,
   input  logic                  FLUSH,
   input  logic                  IN_VALID,
   output logic                  IN_READY,
   input  logic [4*MODESC_W-1:0] IN_MO0,
   input  logic [4*MODESC_W-1:0] IN_MO1,
   input  logic [3:0]            IN_MASK0,
   input  logic [3:0]            IN_MASK1,
   input  logic [GPR_AW-1:0]     IN_WADDR0,
   input  logic [GPR_AW-1:0]     IN_WADDR1,
   output logic                  OUT_VALID,
   input  logic                  OUT_READY,
   output logic [4*MODESC_W-1:0] OUT_MO,
   output logic [3:0]            OUT_MASK,
   output logic [3:0]            OUT_WEN,
   output logic [GPR_AW-1:0]     OUT_WADDR,
   output logic                  OUT_PHASE,
   output logic [CNT_W-1:0]      STAT_ISSUED
);

   issue_state_t state_q, state_d;
   logic         e1_held_q, e1_held_d;
   logic [CNT_W-1:0] stat_q, stat_d;

   slot_t slot0_in, slot1_in;
   slot_t out_in, out_q, buf_q;
   logic  out_load, buf_load;
   logic  e0, e1, last, accept, fire, in_ready, out_valid;

   assign slot0_in = {IN_MO0, IN_MASK0, IN_WADDR0, 1'b0};
   assign slot1_in = {IN_MO1, IN_MASK1, IN_WADDR1, 1'b1};
   assign e0       = phase_empty(slot0_in.lane);
   assign e1       = phase_empty(slot1_in.lane);

   assign last   = (state_q == PH1) | ((state_q == PH0) & e1_held_q);
   assign accept = IN_VALID & in_ready;
   assign fire   = out_valid & OUT_READY;

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state_q   <= IDLE;
         e1_held_q <= 1'b1;
         stat_q    <= '0;
      end else begin
         state_q   <= state_d;
         e1_held_q <= e1_held_d;
         stat_q    <= stat_d;
      end
   end

   // FLUSH wins over everything; a new bundle only arrives when the current one is on its last slot
   always_comb begin
      state_d = state_q;
      if (FLUSH) begin
         state_d = IDLE;
      end else if (accept) begin
         if (!e0) begin
            state_d = PH0;
         end else if (!e1) begin
            state_d = PH1;
         end else begin
            state_d = IDLE;
         end
      end else if ((state_q == PH0) && OUT_READY && !e1_held_q) begin
         state_d = PH1;
      end else if (fire && last) begin
         state_d = IDLE;
      end
   end

   always_comb begin
      out_valid = (state_q != IDLE);
      in_ready  = ~FLUSH & ((state_q == IDLE) | (OUT_READY & last));
      out_load  = 1'b0;
      buf_load  = 1'b0;
      out_in    = buf_q;
      e1_held_d = e1_held_q;
      stat_d    = stat_q + {{(CNT_W-1){1'b0}}, fire};
      if (accept) begin
         e1_held_d = e1;
         if (!e0) begin
            out_load = 1'b1;
            out_in   = slot0_in;
            buf_load = 1'b1;
         end else if (!e1) begin
            out_load = 1'b1;
            out_in   = slot1_in;
         end
      end else if (!FLUSH && (state_q == PH0) && OUT_READY && !e1_held_q) begin
         out_load = 1'b1;
         out_in   = buf_q;
      end
   end

   mtsp_issue_slot_reg u_out_slot (
      .clk      (CLK),
      .rst_n    (nRST),
      .load     (out_load),
      .slot_in  (out_in),
      .slot_out (out_q)
   );

   mtsp_issue_slot_reg u_buf_slot (
      .clk      (CLK),
      .rst_n    (nRST),
      .load     (buf_load),
      .slot_in  (slot1_in),
      .slot_out (buf_q)
   );

   // write enables only mean something while a slot is presented, so they read 0 when idle
   assign IN_READY    = in_ready;
   assign OUT_VALID   = out_valid;
   assign OUT_MO      = out_q.lane;
   assign OUT_MASK    = out_q.mask;
   assign OUT_WADDR   = out_q.waddr;
   assign OUT_PHASE   = out_q.phase;
   assign OUT_WEN     = out_valid ? lane_wen(out_q.lane) : 4'b0000;
   assign STAT_ISSUED = stat_q;

endmodule

// File: tb/tb_mtsp_mo_issue_seq.sv
// Randomised and directed bench for mtsp_mo_issue_seq against a queue-based model
// of pending issue slots.
module tb_mtsp_mo_issue_seq;

   typedef struct {
      logic [27:0] mo;
      logic [3:0]  mask;
      logic [6:0]  waddr;
      logic        phase;
   } exp_slot_t;

   logic        CLK = 1'b0;
   logic        nRST;
   logic        FLUSH;
   logic        IN_VALID;
   logic        IN_READY;
   logic [27:0] IN_MO0, IN_MO1;
   logic [3:0]  IN_MASK0, IN_MASK1;
   logic [6:0]  IN_WADDR0, IN_WADDR1;
   logic        OUT_VALID;
   logic        OUT_READY;
   logic [27:0] OUT_MO;
   logic [3:0]  OUT_MASK;
   logic [3:0]  OUT_WEN;
   logic [6:0]  OUT_WADDR;
   logic        OUT_PHASE;
   logic [15:0] STAT_ISSUED;

   exp_slot_t   exp_q[$];
   logic [15:0] exp_stat;
   int          total;
   int          bad;

   localparam logic [27:0] MO_FULL_A = {7'h01, 7'h12, 7'h23, 7'h34};
   localparam logic [27:0] MO_FULL_B = {7'h0F, 7'h2A, 7'h35, 7'h17};
   localparam logic [27:0] MO_EMPTY  = {7'h40, 7'h45, 7'h7F, 7'h40};
   localparam logic [27:0] MO_XONLY  = {7'h05, 7'h40, 7'h40, 7'h40};

   mtsp_mo_issue_seq dut (
      .CLK         (CLK),
      .nRST        (nRST),
      .FLUSH       (FLUSH),
      .IN_VALID    (IN_VALID),
      .IN_READY    (IN_READY),
      .IN_MO0      (IN_MO0),
      .IN_MO1      (IN_MO1),
      .IN_MASK0    (IN_MASK0),
      .IN_MASK1    (IN_MASK1),
      .IN_WADDR0   (IN_WADDR0),
      .IN_WADDR1   (IN_WADDR1),
      .OUT_VALID   (OUT_VALID),
      .OUT_READY   (OUT_READY),
      .OUT_MO      (OUT_MO),
      .OUT_MASK    (OUT_MASK),
      .OUT_WEN     (OUT_WEN),
      .OUT_WADDR   (OUT_WADDR),
      .OUT_PHASE   (OUT_PHASE),
      .STAT_ISSUED (STAT_ISSUED)
   );

   always #5 CLK = ~CLK;

   function automatic logic all_off(input logic [27:0] m);
      return m[27] & m[20] & m[13] & m[6];
   endfunction

   function automatic logic [3:0] wen_of(input logic [27:0] m);
      return {~m[27], ~m[20], ~m[13], ~m[6]};
   endfunction

   function automatic logic [27:0] rand_mo();
      logic [27:0] m;
      m = {$urandom, $urandom} & 28'hFFF_FFFF;
      if ($urandom_range(0, 2) == 0) begin
         m = m | {7'h40, 7'h40, 7'h40, 7'h40};
      end
      return m;
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
      end
   endtask

   // one clock of stimulus: drive, compare against the model, then advance the model at the edge
   task automatic applyStimulus(input logic v, input logic [27:0] m0, input logic [27:0] m1,
                                input logic [3:0] k0, input logic [3:0] k1,
                                input logic [6:0] w0, input logic [6:0] w1,
                                input logic ordy, input logic fl, input bit chk);
      logic exp_ready;
      exp_slot_t s;
      @(negedge CLK);
      IN_VALID = v; IN_MO0 = m0; IN_MO1 = m1; IN_MASK0 = k0; IN_MASK1 = k1;
      IN_WADDR0 = w0; IN_WADDR1 = w1; OUT_READY = ordy; FLUSH = fl;
      #1;
      exp_ready = !fl && (exp_q.size() == 0 || (ordy && exp_q.size() == 1));
      if (chk) begin
         checkOutput("in_ready", {31'd0, IN_READY}, {31'd0, exp_ready});
         checkOutput("out_valid", {31'd0, OUT_VALID}, {31'd0, exp_q.size() > 0});
         checkOutput("stat", {16'd0, STAT_ISSUED}, {16'd0, exp_stat});
         if (exp_q.size() > 0) begin
            checkOutput("out_mo", {4'd0, OUT_MO}, {4'd0, exp_q[0].mo});
            checkOutput("out_mask", {28'd0, OUT_MASK}, {28'd0, exp_q[0].mask});
            checkOutput("out_waddr", {25'd0, OUT_WADDR}, {25'd0, exp_q[0].waddr});
            checkOutput("out_phase", {31'd0, OUT_PHASE}, {31'd0, exp_q[0].phase});
            checkOutput("out_wen", {28'd0, OUT_WEN}, {28'd0, wen_of(exp_q[0].mo)});
         end
      end
      @(posedge CLK);
      if (exp_q.size() > 0 && ordy) begin
         void'(exp_q.pop_front());
         exp_stat++;
      end
      if (fl) begin
         exp_q.delete();
      end else if (v && exp_ready) begin
         if (!all_off(m0)) begin
            s.mo = m0; s.mask = k0; s.waddr = w0; s.phase = 1'b0;
            exp_q.push_back(s);
         end
         if (!all_off(m1)) begin
            s.mo = m1; s.mask = k1; s.waddr = w1; s.phase = 1'b1;
            exp_q.push_back(s);
         end
      end
   endtask

   task automatic idleCycle(input logic ordy);
      applyStimulus(1'b0, 28'd0, 28'd0, 4'h0, 4'h0, 7'h00, 7'h00, ordy, 1'b0, 1'b1);
   endtask

   // asserts reset between clock edges and checks that outputs clear without waiting for a clock
   task automatic resetMidCycle();
      @(negedge CLK);
      #2;
      nRST = 1'b0;
      IN_VALID = 1'b0; FLUSH = 1'b0;
      #1;
      checkOutput("rst_out_valid", {31'd0, OUT_VALID}, 32'd0);
      checkOutput("rst_stat", {16'd0, STAT_ISSUED}, 32'd0);
      checkOutput("rst_out_mo", {4'd0, OUT_MO}, 32'd0);
      checkOutput("rst_out_mask", {28'd0, OUT_MASK}, 32'd0);
      checkOutput("rst_out_wen", {28'd0, OUT_WEN}, 32'd0);
      checkOutput("rst_out_waddr", {25'd0, OUT_WADDR}, 32'd0);
      checkOutput("rst_out_phase", {31'd0, OUT_PHASE}, 32'd0);
      exp_q.delete();
      exp_stat = '0;
      @(negedge CLK);
      #2;
      nRST = 1'b1;
   endtask

   initial begin
      total = 0; bad = 0; exp_stat = '0;
      nRST = 1'b0; FLUSH = 1'b0; IN_VALID = 1'b0; OUT_READY = 1'b0;
      IN_MO0 = '0; IN_MO1 = '0; IN_MASK0 = '0; IN_MASK1 = '0; IN_WADDR0 = '0; IN_WADDR1 = '0;
      #2;
      checkOutput("init_out_valid", {31'd0, OUT_VALID}, 32'd0);
      checkOutput("init_stat", {16'd0, STAT_ISSUED}, 32'd0);
      #10;
      nRST = 1'b1;
      idleCycle(1'b1);

      $display("[TB] full two-phase bundle");
      applyStimulus(1'b1, MO_FULL_A, MO_FULL_B, 4'hA, 4'h5, 7'h05, 7'h25, 1'b1, 1'b0, 1'b1);
      idleCycle(1'b1);
      idleCycle(1'b1);
      idleCycle(1'b1);
      checkOutput("full_stat_two", {16'd0, STAT_ISSUED}, 32'd2);

      $display("[TB] phase #0 empty, back-to-back bundles");
      applyStimulus(1'b1, MO_EMPTY, MO_XONLY, 4'h1, 4'h8, 7'h11, 7'h12, 1'b1, 1'b0, 1'b1);
      applyStimulus(1'b1, MO_EMPTY, MO_XONLY, 4'h2, 4'h9, 7'h21, 7'h22, 1'b1, 1'b0, 1'b1);
      checkOutput("xonly_wen", {28'd0, OUT_WEN}, 32'h8);
      idleCycle(1'b1);
      idleCycle(1'b1);

      $display("[TB] fully empty bundles");
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1'b1, MO_EMPTY, MO_EMPTY, 4'hF, 4'hF, 7'h33, 7'h34, 1'b1, 1'b0, 1'b1);
      end
      idleCycle(1'b1);

      $display("[TB] stall during phase #0");
      applyStimulus(1'b1, MO_FULL_B, MO_FULL_A, 4'h3, 4'hC, 7'h41, 7'h42, 1'b0, 1'b0, 1'b1);
      for (int i = 0; i < 5; i++) begin
         applyStimulus(1'b1, MO_FULL_A, MO_FULL_A, 4'h7, 4'h7, 7'h7F, 7'h7F, 1'b0, 1'b0, 1'b1);
      end
      idleCycle(1'b1);
      idleCycle(1'b1);
      idleCycle(1'b1);

      $display("[TB] flush during phase #0");
      applyStimulus(1'b1, MO_FULL_A, MO_FULL_B, 4'h6, 4'h9, 7'h51, 7'h52, 1'b0, 1'b0, 1'b1);
      applyStimulus(1'b1, MO_FULL_B, MO_FULL_B, 4'hE, 4'hD, 7'h61, 7'h62, 1'b0, 1'b1, 1'b1);
      idleCycle(1'b1);
      idleCycle(1'b1);
      applyStimulus(1'b1, MO_FULL_A, MO_FULL_B, 4'h6, 4'h9, 7'h53, 7'h54, 1'b1, 1'b0, 1'b1);
      applyStimulus(1'b1, MO_FULL_B, MO_FULL_B, 4'hE, 4'hD, 7'h63, 7'h64, 1'b1, 1'b1, 1'b1);
      idleCycle(1'b1);

      $display("[TB] reset during phase #0");
      applyStimulus(1'b1, MO_FULL_A, MO_FULL_B, 4'h4, 4'h2, 7'h0A, 7'h0B, 1'b0, 1'b0, 1'b1);
      resetMidCycle();
      idleCycle(1'b0);
      idleCycle(1'b1);

      $display("[TB] randomised traffic");
      for (int i = 0; i < 1500; i++) begin
         applyStimulus($urandom_range(0, 3) != 0, rand_mo(), rand_mo(),
                       4'($urandom), 4'($urandom), 7'($urandom), 7'($urandom),
                       $urandom_range(0, 3) != 0, $urandom_range(0, 19) == 0, 1'b1);
      end
      idleCycle(1'b1);
      idleCycle(1'b1);

      $display("[TB] statistics counter wrap");
      resetMidCycle();
      while (exp_stat != 16'hFFFF) begin
         applyStimulus(1'b1, MO_EMPTY, MO_XONLY, 4'h8, 4'h8, 7'h01, 7'h02, 1'b1, 1'b0, 1'b0);
      end
      idleCycle(1'b1);
      idleCycle(1'b1);
      checkOutput("wrap_stat_zero", {16'd0, STAT_ISSUED}, 32'd0);

      $display("[TB] test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/mtsp_mo_issue_seq.md
Name: mtsp_mo_issue_seq

Overview:
- Downstream of the MO dispatch stage. Accepts one dispatched bundle per handshake: phase #0 and phase #1 micro-op descriptors for X/Y/Z/W, plus MO masks and GPR write addresses.
- Serialises each bundle into up to two per-cycle issue slots for the vector ALU pipe, phase #0 first.
- Skips phases in which every lane is disabled.
- Output is fully registered, with a valid/ready handshake on both sides.

Parameters:
- MODESC_W, 7, width of one lane descriptor: {nEN, ALT, SEL, MO[3:0]}. nEN is the MSB.
- GPR_AW, 7, GPR write-address width.
- CNT_W, 16, width of the issued-phase statistics counter.

Ports:
- CLK  in  1  clock
- nRST  in  1  reset; one clock; reset is asynchronous and active-low
- FLUSH  in  1  synchronous discard of the held bundle
- IN_VALID  in  1  upstream bundle valid
- IN_READY  out  1  bundle accepted when IN_VALID & IN_READY
- IN_MO0  in  4*MODESC_W  phase #0 descriptors {X,Y,Z,W}, X at MSB
- IN_MO1  in  4*MODESC_W  phase #1 descriptors {X,Y,Z,W}, X at MSB
- IN_MASK0, IN_MASK1  in  4  phase MO masks
- IN_WADDR0, IN_WADDR1  in  GPR_AW  phase write addresses
- OUT_VALID  out  1  issue slot valid
- OUT_READY  in  1  ALU pipe accepts slot
- OUT_MO  out  4*MODESC_W  issued lane descriptors
- OUT_MASK  out  4  issued MO mask
- OUT_WEN  out  4  per-lane write enable, equal to ~nEN of each lane
- OUT_WADDR  out  GPR_AW  issued write address
- OUT_PHASE  out  1  0 = phase #0, 1 = phase #1
- STAT_ISSUED  out  CNT_W  count of issued phases

Behaviour:
- Phase empty: all four lane nEN bits are 1. E0 and E1 are computed from the input bundle at accept time and stored with it.
- States:
  - IDLE: no slot held.
  - PH0: phase #0 on the output, phase #1 held in the buffer.
  - PH1: phase #1 on the output.
- last = (state==PH1) | (state==PH0 & E1_held).
- IN_READY = ~FLUSH & (state==IDLE | (OUT_READY & last)). This gives one bundle per cycle when a phase is skipped, otherwise one bundle per two cycles.
- On accept (next state):
  - ~E0 → PH0: phase #0 loaded to the output, phase #1 to the buffer.
  - E0 & ~E1 → PH1: phase #1 loaded directly to the output.
  - E0 & E1 → IDLE: bundle consumed, nothing issued.
- PH0 with OUT_READY & ~E1_held → PH1: buffer copied to the output.
- Any issued state with OUT_READY & last & no accept → IDLE.
- Latency: a bundle accepted at edge N shows its first slot with OUT_VALID=1 at N+1 (registered output).
- OUT_VALID = (state != IDLE). While OUT_VALID & ~OUT_READY, all OUT_* hold stable.
- STAT_ISSUED increments by 1 on each OUT_VALID & OUT_READY and wraps modulo 2^CNT_W. Skipped phases and fully-empty bundles are not counted.
- FLUSH:
  - Next state is IDLE; the buffer is discarded and IN_READY is 0.
  - If OUT_READY was high in the same cycle, the slot still counts as issued.
  - FLUSH has priority over accept.
- Reset (nRST low, asynchronous): state IDLE; OUT_VALID 0; OUT_MO, OUT_MASK, OUT_WEN, OUT_WADDR, OUT_PHASE all 0; STAT_ISSUED 0; IN_READY 1 once FLUSH is low.
- Reset mid-bundle drops it silently.
- OUT_WEN is derived from the registered OUT_MO; it is not stored separately.
- OUT_WADDR passes the dispatch-computed address unmodified. No further relative offset is applied.

Decomposition:
- Shared package mtsp_issue_pkg holds:
  - typedef modesc_t {nEN, alt, sel, mo[3:0]}
  - typedef slot_t {modesc_t lane[4], mask[3:0], waddr, phase}
  - enum issue_state_t {IDLE, PH0, PH1}
  - function phase_empty()
- One sub-module, mtsp_issue_slot_reg: a load/hold register for slot_t with async active-low clear, instantiated for both the output slot and the phase #1 buffer.

Test Plan:
- Reset with nRST=0 mid-PH0 → OUT_VALID=0, STAT_ISSUED=0 immediately (asynchronous), IN_READY=1 on the next cycle.
- Full bundle (all nEN=0 in both phases, WADDR0=7'h05, WADDR1=7'h25), OUT_READY=1 → slot {PHASE0, WADDR 05, WEN 4'hF} at N+1, then {PHASE1, WADDR 25} at N+2; IN_READY=0 at N+1; STAT_ISSUED=2.
- Phase #0 empty, phase #1 X-only enabled → single slot PHASE=1, OUT_WEN=4'b1000; a back-to-back second bundle is accepted in the same cycle (IN_READY=1).
- Both phases empty, 3 consecutive bundles → OUT_VALID stays 0, IN_READY stays 1, STAT_ISSUED unchanged.
- OUT_READY=0 for 5 cycles during PH0 → OUT_* stable, IN_READY=0; on release PH1 issues next cycle.
- FLUSH asserted in PH0 with IN_VALID=1 → next cycle IDLE, phase #1 never issued, bundle not accepted; preload STAT_ISSUED=16'hFFFF and issue one slot → wraps to 0.
